// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: each channel emits a one-clock
// pulse every Pe cycles (periodic) or once Pe cycles after start (one-shot).
module tick_gen_multi #(
    parameter int CH        = 4,
    parameter int W         = 24,
    parameter int DEFAULT_M = 1200000,
    localparam int CHW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           wr,
    input  logic [CHW-1:0] wr_ch,
    input  logic [W-1:0]   wr_period,
    input  logic           wr_mode,
    input  logic [CH-1:0]  start,
    input  logic [CH-1:0]  stop,
    output logic [CH-1:0]  tick,
    output logic [CH-1:0]  busy
);

    localparam logic [W-1:0] DEF_P = W'(DEFAULT_M);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [W-1:0] r_period;
        logic         r_mode;
        logic [W-1:0] r_cnt;
        logic         r_active;
        logic         r_tick;
        logic         w_sel;
        logic [W-1:0] w_last;
        logic         w_wrap;

        // An out-of-range wr_ch matches no channel, so the write is dropped.
        assign w_sel  = wr && (int'(wr_ch) == g);
        // A period of 0 behaves as 1, so the last count is 0 in both cases.
        assign w_last = (r_period == '0) ? '0 : r_period - W'(1);
        // >= so a period shrunk below the running count wraps at once.
        assign w_wrap = (r_cnt >= w_last);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_period <= DEF_P;
                r_mode   <= 1'b0;
                r_cnt    <= '0;
                r_active <= 1'b0;
                r_tick   <= 1'b0;
            end else begin
                if (w_sel) begin
                    r_period <= wr_period;
                    r_mode   <= wr_mode;
                end
                if (stop[g]) begin
                    r_active <= 1'b0;
                    r_cnt    <= '0;
                    r_tick   <= 1'b0;
                end else if (start[g]) begin
                    r_active <= 1'b1;
                    r_cnt    <= '0;
                    r_tick   <= 1'b0;
                end else if (r_active && en) begin
                    if (w_wrap) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                        if (r_mode) begin
                            r_active <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt + W'(1);
                        r_tick <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                end
            end
        end

        assign tick[g] = r_tick;
        assign busy[g] = r_active;
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed and randomized checks of tick_gen_multi against an elapsed-cycle
// reference model of each channel.
module tb_tick_gen_multi;

    localparam int CH  = 4;
    localparam int W   = 24;
    localparam int DM  = 10;
    localparam int CHW = 2;

    logic           clk;
    logic           rst;
    logic           en;
    logic           wr;
    logic [CHW-1:0] wr_ch;
    logic [W-1:0]   wr_period;
    logic           wr_mode;
    logic [CH-1:0]  start;
    logic [CH-1:0]  stop;
    logic [CH-1:0]  tick;
    logic [CH-1:0]  busy;

    tick_gen_multi #(.CH(CH), .W(W), .DEFAULT_M(DM)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr        (wr),
        .wr_ch     (wr_ch),
        .wr_period (wr_period),
        .wr_mode   (wr_mode),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: each channel counts enabled cycles since its phase began
    int            m_period  [CH];
    bit            m_mode    [CH];
    int            m_elapsed [CH];
    bit            m_active  [CH];
    logic [CH-1:0] m_tick;

    // per-window statistics for directed checks
    int base;
    int tcnt   [CH];
    int tfirst [CH];
    int tsec   [CH];
    int bl0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_period[i]  = DM;
            m_mode[i]    = 1'b0;
            m_elapsed[i] = 0;
            m_active[i]  = 1'b0;
        end
        m_tick = '0;
    endtask

    task automatic model_edge();
        int pe;
        for (int i = 0; i < CH; i++) begin
            pe = (m_period[i] < 1) ? 1 : m_period[i];
            m_tick[i] = 1'b0;
            if (stop[i]) begin
                m_active[i]  = 1'b0;
                m_elapsed[i] = 0;
            end else if (start[i]) begin
                m_active[i]  = 1'b1;
                m_elapsed[i] = 0;
            end else if (m_active[i] && en) begin
                if (m_elapsed[i] + 1 >= pe) begin
                    m_elapsed[i] = 0;
                    m_tick[i]    = 1'b1;
                    if (m_mode[i]) m_active[i] = 1'b0;
                end else begin
                    m_elapsed[i]++;
                end
            end
        end
        if (wr && int'(wr_ch) < CH) begin
            m_period[wr_ch] = int'(wr_period);
            m_mode[wr_ch]   = wr_mode;
        end
    endtask

    function automatic logic [CH-1:0] model_busy();
        logic [CH-1:0] b;
        for (int i = 0; i < CH; i++) b[i] = m_active[i];
        return b;
    endfunction

    task automatic clear_stats();
        base = cyc;
        bl0  = 0;
        for (int i = 0; i < CH; i++) begin
            tcnt[i]   = 0;
            tfirst[i] = -1;
            tsec[i]   = -1;
        end
    endtask

    // one clock: model follows the edge, outputs checked 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("busy", 32'(busy), 32'(model_busy()));
        for (int i = 0; i < CH; i++) begin
            if (tick[i] === 1'b1) begin
                tcnt[i]++;
                if (tfirst[i] < 0) tfirst[i] = cyc - base;
                else if (tsec[i] < 0) tsec[i] = cyc - base;
            end
        end
        if (busy[0] !== 1'b1) bl0++;
        start = '0;
        stop  = '0;
        wr    = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write_ch(input int ch, input int p, input bit mode);
        wr        = 1'b1;
        wr_ch     = CHW'(ch);
        wr_period = W'(p);
        wr_mode   = mode;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; wr = 1'b0; wr_ch = '0; wr_period = '0;
        wr_mode = 1'b0; start = '0; stop = '0;
        model_reset();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        en  = 1'b1;

        // default period after reset
        start = 4'b0001;
        step();
        clear_stats();
        steps(25);
        chk("def_first", 32'(tfirst[0]), 32'd10);
        chk("def_second", 32'(tsec[0]), 32'd20);
        chk("def_count", 32'(tcnt[0]), 32'd2);
        chk("def_busy_low", 32'(bl0), 32'd0);
        chk("def_others", 32'(tcnt[1] + tcnt[2] + tcnt[3]), 32'd0);
        stop = 4'b0001;
        step();

        // programmed periods, ch0 written with 0
        write_ch(0, 0, 1'b0); step();
        write_ch(1, 2, 1'b0); step();
        write_ch(2, 3, 1'b0); step();
        write_ch(3, 7, 1'b0); step();
        start = 4'b1111;
        step();
        clear_stats();
        steps(42);
        chk("prog_cnt0", 32'(tcnt[0]), 32'd42);
        chk("prog_cnt1", 32'(tcnt[1]), 32'd21);
        chk("prog_cnt2", 32'(tcnt[2]), 32'd14);
        chk("prog_cnt3", 32'(tcnt[3]), 32'd6);
        stop = 4'b1111;
        step();

        // one-shot on ch2, configured in the start cycle
        write_ch(2, 5, 1'b1);
        start = 4'b0100;
        step();
        clear_stats();
        for (int j = 1; j <= 55; j++) begin
            step();
            if (j == 4) chk("os_busy_before", 32'(busy[2]), 32'd1);
            if (j == 5) chk("os_busy_fall", 32'(busy[2]), 32'd0);
        end
        chk("os_count", 32'(tcnt[2]), 32'd1);
        chk("os_first", 32'(tfirst[2]), 32'd5);
        start = 4'b0100;
        step();
        clear_stats();
        steps(10);
        chk("os_re_count", 32'(tcnt[2]), 32'd1);
        chk("os_re_first", 32'(tfirst[2]), 32'd5);

        // shrink period below running count on ch1
        write_ch(1, 100, 1'b0);
        start = 4'b0010;
        step();
        steps(50);
        write_ch(1, 4, 1'b0);
        step();
        clear_stats();
        steps(9);
        chk("shrink_first", 32'(tfirst[1]), 32'd1);
        chk("shrink_second", 32'(tsec[1]), 32'd5);
        chk("shrink_count", 32'(tcnt[1]), 32'd3);

        // restart at cnt 3 restores the full phase
        write_ch(1, 100, 1'b0);
        start = 4'b0010;
        step();
        steps(3);
        start = 4'b0010;
        step();
        clear_stats();
        steps(101);
        chk("restart_first", 32'(tfirst[1]), 32'd100);
        chk("restart_count", 32'(tcnt[1]), 32'd1);

        // stop wins over start
        start = 4'b0010;
        stop  = 4'b0010;
        step();
        chk("stopstart_busy", 32'(busy[1]), 32'd0);
        clear_stats();
        steps(10);
        chk("stopstart_ticks", 32'(tcnt[1]), 32'd0);

        // en held low for 13 cycles right after a tick on ch3
        write_ch(3, 8, 1'b0);
        start = 4'b1000;
        step();
        clear_stats();
        steps(8);
        chk("en_first", 32'(tfirst[3]), 32'd8);
        en = 1'b0;
        step();
        chk("en_no_stretch", 32'(tick[3]), 32'd0);
        steps(12);
        en = 1'b1;
        steps(10);
        chk("en_delayed", 32'(tsec[3]), 32'd29);
        chk("en_count", 32'(tcnt[3]), 32'd2);
        stop = 4'b1000;
        step();

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < CH; i++) begin
                start[i] = ($urandom_range(0, 15) == 0);
                stop[i]  = ($urandom_range(0, 23) == 0);
            end
            if ($urandom_range(0, 4) == 0)
                write_ch(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 12)),
                         1'($urandom_range(0, 1)));
            step();
        end
        en = 1'b1;

        // asynchronous reset while tick[3] is high
        write_ch(3, 1, 1'b0);
        start = 4'b1000;
        step();
        steps(2);
        chk("pre_rst_tick3", 32'(tick[3]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        model_reset();
        #1;
        rst = 1'b0;
        steps(3);
        start = 4'b1000;
        step();
        clear_stats();
        steps(12);
        chk("post_rst_first", 32'(tfirst[3]), 32'd10);
        chk("post_rst_count", 32'(tcnt[3]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Multi-channel, run-time programmable tick generator: each of CH channels produces a registered, one-clock-wide pulse every P cycles (periodic mode) or once, P cycles after a start (one-shot mode). It replaces fixed compile-time dividers in the design. UART baud ticks, SPI bit timing and LED/timeout timers all come from one block whose periods a host or control FSM can rewrite without resynthesis.

## Interface
- CH, default 4: number of independent channels (1..16).
- W, default 24: counter/period width in bits.
- DEFAULT_M, default 1200000: reset period for every channel (100 ms at 12 MHz); must fit in W bits.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global count enable; low freezes all counters.
- wr  in  1  write strobe for the channel config registers.
- wr_ch  in  $clog2(CH) (min 1)  channel selected by wr.
- wr_period  in  W  new period P for wr_ch.
- wr_mode  in  1  new mode for wr_ch: 0 periodic, 1 one-shot.
- start  in  CH  per-channel start/restart pulse.
- stop  in  CH  per-channel stop pulse.
- tick  out  CH  registered one-cycle tick per channel.
- busy  out  CH  channel active (counting or armed).

## Operation
- Per channel state: period[W-1:0], mode, cnt[W-1:0], active, tick register.
- Reset values (asynchronous): period = DEFAULT_M, mode = 0, cnt = 0, active = 0, tick = 0, busy = 0.
- Effective period Pe = max(period, 1). A period of 0 behaves as 1.
- Write: on an edge with wr=1, period[wr_ch] and mode[wr_ch] are loaded. cnt and active are untouched. An out-of-range wr_ch (≥ CH) is ignored.
- Start: start[i]=1 sets active, clears cnt. A start on an active channel restarts the phase.
- Stop: stop[i]=1 clears active and cnt. stop beats start when both are high in the same cycle.
- Counting (active and en both high):
  - If cnt ≥ Pe-1: cnt ← 0 and tick ← 1. In one-shot mode, active also ← 0.
  - Otherwise: cnt ← cnt+1 and tick ← 0.
- The ≥ compare means that writing a period smaller than the current cnt wraps on the next enabled edge, with no overflow.
- When en=0 or active=0: cnt holds (unless start or stop acts) and tick ← 0.
- Mode change while active: takes effect at the next wrap decision.
- busy = active (registered).
- Channels are fully independent, with no shared arbitration.

## Timing
- start sampled at edge E0 → tick high for exactly one cycle following edge E0+Pe, given en held high.
- Periodic mode: subsequent ticks after edges E0+2Pe, E0+3Pe, … The pulse spacing is exactly Pe cycles.
- Pe=1: tick is high every cycle from E0+1 on (periodic mode).
- One-shot mode: exactly one tick after edge E0+Pe. busy falls at the same edge tick rises.
- en low for k cycles delays all later ticks by exactly k cycles. A tick that is high while en falls still lasts only one cycle.
- Write and start to the same channel in the same cycle: the new period and mode apply to that start.
- stop: tick is 0 from the next cycle on. A tick already registered in the stop cycle is still visible for that one cycle.
- rst asserted mid-count: outputs clear immediately, without waiting for a clock edge. After rst deasserts, channels stay idle until started.
- Latency from any input to tick or busy is 1 clock, and every output is registered.

## Test plan
- Reset/default: release rst, start[0] with en=1, then measure the interval between the first two ticks. Use DEFAULT_M overridden to 10 → ticks after edges E0+10 and E0+20; busy[0]=1 throughout; other channels tick=0, busy=0.
- Programmed periods, all channels: write periods 1, 2, 3, 7 to ch0..3, start all together. Over 42 cycles expect tick counts 42, 21, 14, 6, each pulse exactly 1 cycle wide. Period 0 on ch0 behaves like 1.
- One-shot: ch2 with mode=1 and P=5, start at E0 → a single tick after edge E0+5, busy low from the same edge, no further tick in 50 cycles. Restart → another single tick 5 cycles later.
- Mid-run changes on ch1 (P=100):
  - Write P=4 at cnt=50 → tick on the next enabled edge, then every 4 cycles.
  - Restart at cnt=3 → next tick 100 cycles after the restart.
  - stop together with start → busy=0, no ticks.
- en gating: hold en low for 13 cycles in the middle of a P=8 period → that tick is delayed by exactly 13 cycles and no pulse stretches.
- Async reset: assert rst between clock edges while tick[3] is high → tick and busy go 0 before the next edge. period reads back as DEFAULT_M on the next start.
